// File: rtl/pipe_ctrl.sv
// ============================================================================
// pipe_ctrl : hazard/stall/flush controller for a 5-stage in-order pipeline.
// Optional performance counters are enabled by defining PIPE_CTRL_PERF_EN.
// Revision  : 1.0
// ============================================================================
`default_nettype none

module pipe_ctrl #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1_id,
  input  logic [4:0]  id_rs2_id,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic [4:0]  ex_rd_id,
  input  logic        ex_is_load,
  input  logic        ex_mispredict,
  input  logic        m_mem_req,
  input  logic        dmem_ack,
  input  logic        wb_halt,
  output logic [1:0]  if_id_ctr,
  output logic [1:0]  id_ex_ctr,
  output logic [1:0]  ex_m_ctr,
  output logic [1:0]  m_wb_ctr,
  output logic        pc_en,
  output logic        pc_redirect,
  output logic        halted,
  output logic        mem_err,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  localparam logic [1:0] CTR_NORMAL   = 2'b00;
  localparam logic [1:0] CTR_STALL    = 2'b01;
  localparam logic [1:0] CTR_BUBBLE   = 2'b10;
  localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_INIT     = 2'd0,
    S_RUN      = 2'd1,
    S_MEM_WAIT = 2'd2,
    S_HALTED   = 2'd3
  } state_t;

  state_t     state;
  logic [7:0] wait_cnt;
  logic       mem_err_q;
  logic       mem_stall;
  logic       load_use;

  assign mem_stall = m_mem_req && !dmem_ack;
  assign load_use  = ex_is_load && (ex_rd_id != 5'd0) &&
                     ((id_use_rs1 && (id_rs1_id == ex_rd_id)) ||
                      (id_use_rs2 && (id_rs2_id == ex_rd_id)));

  // Outputs follow the state and live inputs; reset forces the INIT pattern.
  always_comb begin
    if_id_ctr   = CTR_NORMAL;
    id_ex_ctr   = CTR_NORMAL;
    ex_m_ctr    = CTR_NORMAL;
    m_wb_ctr    = CTR_NORMAL;
    pc_en       = 1'b0;
    pc_redirect = 1'b0;
    if (rst || state == S_INIT || (state != S_HALTED && wb_halt)) begin
      if_id_ctr = CTR_BUBBLE;
      id_ex_ctr = CTR_BUBBLE;
      ex_m_ctr  = CTR_BUBBLE;
      m_wb_ctr  = CTR_BUBBLE;
    end else if (state == S_HALTED) begin
      if_id_ctr = CTR_STALL;
      id_ex_ctr = CTR_STALL;
      ex_m_ctr  = CTR_STALL;
      m_wb_ctr  = CTR_STALL;
    end else if (mem_stall) begin
      if_id_ctr = CTR_STALL;
      id_ex_ctr = CTR_STALL;
      ex_m_ctr  = CTR_STALL;
      m_wb_ctr  = CTR_BUBBLE;
    end else if (ex_mispredict) begin
      if_id_ctr   = CTR_BUBBLE;
      id_ex_ctr   = CTR_BUBBLE;
      pc_en       = 1'b1;
      pc_redirect = 1'b1;
    end else if (load_use) begin
      if_id_ctr = CTR_STALL;
      id_ex_ctr = CTR_BUBBLE;
    end else begin
      pc_en = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_INIT;
      wait_cnt  <= 8'd0;
      mem_err_q <= 1'b0;
    end else begin
      case (state)
        S_INIT: state <= S_RUN;
        S_RUN, S_MEM_WAIT: begin
          if (wb_halt) begin
            state <= S_HALTED;
          end else if (mem_stall) begin
            // wait_cnt holds the number of unacknowledged MEM_WAIT cycles already spent
            if (state == S_MEM_WAIT && wait_cnt == TIMEOUT_LAST) begin
              state     <= S_HALTED;
              mem_err_q <= 1'b1;
            end else begin
              state    <= S_MEM_WAIT;
              wait_cnt <= (state == S_RUN) ? 8'd0 : wait_cnt + 8'd1;
            end
          end else begin
            state <= S_RUN;
          end
        end
        default: state <= state;
      endcase
    end
  end

  assign halted  = (state == S_HALTED);
  assign mem_err = mem_err_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_q;
  logic [31:0] flush_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= 32'd0;
      flush_q <= 32'd0;
    end else begin
      if ((state == S_RUN || state == S_MEM_WAIT) && !pc_en)
        stall_q <= stall_q + 32'd1;
      if (pc_redirect)
        flush_q <= flush_q + 32'd1;
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = 32'd0;
  assign flush_cnt = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
// ============================================================================
// tb_pipe_ctrl : directed vector table, counter sequence and randomized run
// against a cycle-level reference model of the pipeline controller.
// Revision     : 1.0
// ============================================================================
`default_nettype none

module tb_pipe_ctrl;

  localparam int TO = 4;
`ifdef PIPE_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [4:0]  id_rs1_id, id_rs2_id, ex_rd_id;
  logic        id_use_rs1, id_use_rs2, ex_is_load, ex_mispredict;
  logic        m_mem_req, dmem_ack, wb_halt;
  logic [1:0]  if_id_ctr, id_ex_ctr, ex_m_ctr, m_wb_ctr;
  logic        pc_en, pc_redirect, halted, mem_err;
  logic [31:0] stall_cnt, flush_cnt;

  pipe_ctrl #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .id_rs1_id(id_rs1_id), .id_rs2_id(id_rs2_id),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd_id(ex_rd_id), .ex_is_load(ex_is_load),
    .ex_mispredict(ex_mispredict),
    .m_mem_req(m_mem_req), .dmem_ack(dmem_ack), .wb_halt(wb_halt),
    .if_id_ctr(if_id_ctr), .id_ex_ctr(id_ex_ctr),
    .ex_m_ctr(ex_m_ctr), .m_wb_ctr(m_wb_ctr),
    .pc_en(pc_en), .pc_redirect(pc_redirect),
    .halted(halted), .mem_err(mem_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nvec  = 0;
  int nfail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2, input logic [4:0] exrd,
                       input logic exld, input logic mis, input logic mreq,
                       input logic ack, input logic halt);
    rst = r; id_rs1_id = rs1; id_use_rs1 = u1; id_rs2_id = rs2; id_use_rs2 = u2;
    ex_rd_id = exrd; ex_is_load = exld; ex_mispredict = mis;
    m_mem_req = mreq; dmem_ack = ack; wb_halt = halt;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: tracks "just reset", "halted", and how many wait cycles
  // have elapsed on an outstanding memory access.
  bit          m_first, m_halted, m_err, m_inwait;
  int          m_wait;
  logic [31:0] m_stall, m_flush;
  logic [7:0]  e_ctr;
  logic        e_pc, e_redir;

  task automatic model_eval();
    bit lu;
    lu = ex_is_load && ex_rd_id != 0 &&
         ((id_use_rs1 && id_rs1_id == ex_rd_id) || (id_use_rs2 && id_rs2_id == ex_rd_id));
    e_pc = 1'b0; e_redir = 1'b0;
    if (rst || m_first)             e_ctr = 8'hAA;
    else if (m_halted)              e_ctr = 8'h55;
    else if (wb_halt)               e_ctr = 8'hAA;
    else if (m_mem_req && !dmem_ack) e_ctr = 8'h56;
    else if (ex_mispredict) begin e_ctr = 8'hA0; e_pc = 1'b1; e_redir = 1'b1; end
    else if (lu)                    e_ctr = 8'h60;
    else begin                      e_ctr = 8'h00; e_pc = 1'b1; end
  endtask

  task automatic model_advance();
    if (rst) begin
      m_first = 1; m_halted = 0; m_err = 0; m_inwait = 0; m_wait = 0;
      m_stall = 0; m_flush = 0;
    end else if (m_first) begin
      m_first = 0;
    end else if (!m_halted) begin
      if (!e_pc)   m_stall = m_stall + 1;
      if (e_redir) m_flush = m_flush + 1;
      if (wb_halt) begin
        m_halted = 1; m_inwait = 0;
      end else if (m_mem_req && !dmem_ack) begin
        if (m_inwait) begin
          m_wait++;
          if (m_wait >= TO) begin m_halted = 1; m_err = 1; m_inwait = 0; end
        end else begin
          m_inwait = 1; m_wait = 0;
        end
      end else begin
        m_inwait = 0;
      end
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".ctr"}, {24'd0, if_id_ctr, id_ex_ctr, ex_m_ctr, m_wb_ctr}, {24'd0, e_ctr});
    chk({tag, ".pc_en"}, {31'd0, pc_en}, {31'd0, e_pc});
    chk({tag, ".redir"}, {31'd0, pc_redirect}, {31'd0, e_redir});
    chk({tag, ".halted"}, {31'd0, halted}, {31'd0, m_halted});
    chk({tag, ".mem_err"}, {31'd0, mem_err}, {31'd0, m_err});
    chk({tag, ".stall_cnt"}, stall_cnt, PERF ? m_stall : 32'd0);
    chk({tag, ".flush_cnt"}, flush_cnt, PERF ? m_flush : 32'd0);
  endtask

  typedef struct {
    logic       r;
    logic [4:0] rs1; logic u1; logic [4:0] rs2; logic u2; logic [4:0] exrd;
    logic       exld, mis, mreq, ack, halt;
    logic [7:0] ctr; logic pc; logic rd;
    logic       chkf; logic hlt; logic err;
  } vec_t;

  function automatic vec_t v(input logic r, input logic [4:0] rs1, input logic u1,
                             input logic [4:0] rs2, input logic u2, input logic [4:0] exrd,
                             input logic exld, input logic mis, input logic mreq,
                             input logic ack, input logic halt, input logic [7:0] ctr,
                             input logic pc, input logic rd, input logic chkf,
                             input logic hlt, input logic err);
    vec_t t;
    t.r = r; t.rs1 = rs1; t.u1 = u1; t.rs2 = rs2; t.u2 = u2; t.exrd = exrd;
    t.exld = exld; t.mis = mis; t.mreq = mreq; t.ack = ack; t.halt = halt;
    t.ctr = ctr; t.pc = pc; t.rd = rd; t.chkf = chkf; t.hlt = hlt; t.err = err;
    return t;
  endfunction

  vec_t tbl[37];

  initial begin
    //            r rs1 u1 rs2 u2 rd ld mis req ack hlt  ctr  pc rd chk hlt err
    tbl[0]  = v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'hAA, 0, 0, 0, 0, 0);
    tbl[1]  = v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'hAA, 0, 0, 1, 0, 0);
    tbl[2]  = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'hAA, 0, 0, 1, 0, 0);
    tbl[3]  = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 1, 0, 1, 0, 0);
    tbl[4]  = v(0, 0, 0, 5, 1, 5, 1, 0, 0, 0, 0, 8'h60, 0, 0, 1, 0, 0);
    tbl[5]  = v(0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 8'h00, 1, 0, 1, 0, 0);
    tbl[6]  = v(0, 7, 1, 0, 0, 7, 1, 0, 0, 0, 0, 8'h60, 0, 0, 1, 0, 0);
    tbl[7]  = v(0, 7, 0, 0, 0, 7, 1, 0, 0, 0, 0, 8'h00, 1, 0, 1, 0, 0);
    tbl[8]  = v(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 8'h56, 0, 0, 1, 0, 0);
    tbl[9]  = v(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 8'h56, 0, 0, 1, 0, 0);
    tbl[10] = v(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 8'h56, 0, 0, 1, 0, 0);
    tbl[11] = v(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 8'h00, 1, 0, 1, 0, 0);
    tbl[12] = v(0, 3, 1, 0, 0, 3, 1, 1, 0, 0, 0, 8'hA0, 1, 1, 1, 0, 0);
    tbl[13] = v(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 8'h00, 1, 0, 1, 0, 0);
    tbl[14] = v(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 8'h56, 0, 0, 1, 0, 0);
    tbl[15] = v(0, 0, 0, 5, 1, 5, 1, 0, 0, 0, 0, 8'h60, 0, 0, 1, 0, 0);
    tbl[16] = v(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 8'h56, 0, 0, 1, 0, 0);
    tbl[17] = v(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 8'h56, 0, 0, 1, 0, 0);
    tbl[18] = v(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 8'h56, 0, 0, 1, 0, 0);
    tbl[19] = v(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 8'h56, 0, 0, 1, 0, 0);
    tbl[20] = v(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 8'h56, 0, 0, 1, 0, 0);
    tbl[21] = v(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 8'h55, 0, 0, 1, 1, 1);
    tbl[22] = v(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 8'h55, 0, 0, 1, 1, 1);
    tbl[23] = v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'hAA, 0, 0, 1, 1, 1);
    tbl[24] = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'hAA, 0, 0, 1, 0, 0);
    tbl[25] = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 1, 0, 1, 0, 0);
    tbl[26] = v(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 8'hAA, 0, 0, 1, 0, 0);
    tbl[27] = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h55, 0, 0, 1, 1, 0);
    tbl[28] = v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'hAA, 0, 0, 1, 1, 0);
    tbl[29] = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'hAA, 0, 0, 1, 0, 0);
    tbl[30] = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 1, 0, 1, 0, 0);
    tbl[31] = v(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 8'h56, 0, 0, 1, 0, 0);
    tbl[32] = v(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 8'h56, 0, 0, 1, 0, 0);
    tbl[33] = v(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 8'hAA, 0, 0, 1, 0, 0);
    tbl[34] = v(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 8'hAA, 0, 0, 1, 0, 0);
    tbl[35] = v(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 8'h56, 0, 0, 1, 0, 0);
    tbl[36] = v(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 8'h00, 1, 0, 1, 0, 0);

    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    m_first = 1; m_halted = 0; m_err = 0; m_inwait = 0; m_wait = 0;
    m_stall = 0; m_flush = 0;
    #1;

    // Directed table: one row per clock, outputs sampled mid-cycle.
    for (int i = 0; i < 37; i++) begin
      drive(tbl[i].r, tbl[i].rs1, tbl[i].u1, tbl[i].rs2, tbl[i].u2, tbl[i].exrd,
            tbl[i].exld, tbl[i].mis, tbl[i].mreq, tbl[i].ack, tbl[i].halt);
      @(negedge clk);
      model_eval();
      chk($sformatf("tbl%0d.ctr", i), {24'd0, if_id_ctr, id_ex_ctr, ex_m_ctr, m_wb_ctr},
          {24'd0, tbl[i].ctr});
      chk($sformatf("tbl%0d.pc_en", i), {31'd0, pc_en}, {31'd0, tbl[i].pc});
      chk($sformatf("tbl%0d.redir", i), {31'd0, pc_redirect}, {31'd0, tbl[i].rd});
      if (tbl[i].chkf) begin
        chk($sformatf("tbl%0d.halted", i), {31'd0, halted}, {31'd0, tbl[i].hlt});
        chk($sformatf("tbl%0d.mem_err", i), {31'd0, mem_err}, {31'd0, tbl[i].err});
        chk($sformatf("tbl%0d.stall_cnt", i), stall_cnt, PERF ? m_stall : 32'd0);
        chk($sformatf("tbl%0d.flush_cnt", i), flush_cnt, PERF ? m_flush : 32'd0);
      end
      model_advance();
      tick();
    end

    // Counter sequence: three memory stall cycles, ack, then mispredict + load-use.
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); tick(); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0); tick(); tick(); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    @(negedge clk);
    chk("seq.stall_after_wait", stall_cnt, PERF ? 32'd3 : 32'd0);
    chk("seq.ack_ctr", {24'd0, if_id_ctr, id_ex_ctr, ex_m_ctr, m_wb_ctr}, 32'h00);
    tick();
    drive(0, 0, 0, 9, 1, 9, 1, 1, 0, 0, 0);
    @(negedge clk);
    chk("seq.mis_lu_ctr", {24'd0, if_id_ctr, id_ex_ctr, ex_m_ctr, m_wb_ctr}, 32'hA0);
    chk("seq.mis_lu_redir", {31'd0, pc_redirect}, 32'd1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("seq.flush_cnt", flush_cnt, PERF ? 32'd1 : 32'd0);
    chk("seq.stall_unchanged", stall_cnt, PERF ? 32'd3 : 32'd0);
    tick();

    // Randomized run against the reference model.
    begin
      int held = 0;
      for (int c = 0; c < 3000; c++) begin
        logic r;
        r = (c == 0) || ($urandom_range(0, 199) == 0) || (m_halted && held > 12);
        held = m_halted ? held + 1 : 0;
        drive(r, 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 7) == 0), ($urandom_range(0, 2) == 0),
              1'($urandom_range(0, 1)), ($urandom_range(0, 99) == 0));
        @(negedge clk);
        model_eval();
        check_model($sformatf("rnd%0d", c));
        model_advance();
        tick();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

`default_nettype wire
